// File: rtl/panda_uart_tx_mmio_if.sv
// Data-port bundle between the core's address decoder and the UART transmitter.
// The master drives select/address/data/enables; the slave returns registered read data.
interface panda_uart_tx_mmio_if;
    logic        sel_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [3:0]  we_i;
    logic [31:0] rdata_o;

    modport master (output sel_i, addr_i, wdata_i, we_i, input rdata_o);
    modport slave  (input sel_i, addr_i, wdata_i, we_i, output rdata_o);
endinterface

// File: rtl/panda_uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: software pushes bytes into a FIFO through TXDATA,
// an FSM serialises them LSB first on tx_o with a programmable bit period.
module panda_uart_tx_mmio #(
    parameter int unsigned FifoDepth    = 8,
    parameter logic [15:0] ResetBaudDiv = 16'd867
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    panda_uart_tx_mmio_if.slave  bus,
    output logic                 tx_o,
    output logic                 idle_o
);
    localparam int unsigned    PtrW      = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
    localparam logic [PtrW:0]  FullCount = (PtrW + 1)'(FifoDepth);
    localparam logic [PtrW:0]  CountOne  = (PtrW + 1)'(1);
    localparam logic [PtrW-1:0] PtrOne   = PtrW'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_e;

    state_e          state_q;
    logic [7:0]      shift_q;
    logic [2:0]      bit_idx_q;
    logic [15:0]     baud_q;
    logic            tx_q;
    logic            idle_q;
    logic [15:0]     bauddiv_q;
    logic            overflow_q;
    logic [31:0]     rdata_q;
    logic [31:0]     rdata_d;
    logic            tx_d;

    logic [7:0]      fifo_mem [FifoDepth];
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [PtrW:0]   count_q;

    logic [1:0]      reg_sel;
    logic            wr_txdata;
    logic            ovf_clr;
    logic            ovf_set;
    logic            bd_wr_lo;
    logic            bd_wr_hi;
    logic            fifo_full;
    logic            fifo_empty;
    logic            bit_done;
    logic            push;
    logic            pop;
    logic            busy;
    logic [7:0]      fifo_head;

    wire unused_bits = &{1'b0, bus.addr_i[31:4], bus.addr_i[1:0],
                         bus.wdata_i[31:16], bus.we_i[3:2]};

    always_comb begin
        reg_sel    = bus.addr_i[3:2];
        wr_txdata  = bus.sel_i && (reg_sel == 2'd0) && bus.we_i[0];
        ovf_clr    = bus.sel_i && (reg_sel == 2'd1) && bus.we_i[0] && bus.wdata_i[3];
        bd_wr_lo   = bus.sel_i && (reg_sel == 2'd2) && bus.we_i[0];
        bd_wr_hi   = bus.sel_i && (reg_sel == 2'd2) && bus.we_i[1];
        fifo_full  = (count_q == FullCount);
        fifo_empty = (count_q == '0);
        busy       = (state_q != ST_IDLE);
        fifo_head  = fifo_mem[rd_ptr_q];
        // Live compare: shrinking BAUDDIV mid-bit ends the bit at once.
        bit_done   = (baud_q >= bauddiv_q);
        pop        = !fifo_empty &&
                     ((state_q == ST_IDLE) || ((state_q == ST_STOP) && bit_done));
        // A same-edge pop frees the slot, so a push while full still lands.
        push       = wr_txdata && (!fifo_full || pop);
        ovf_set    = wr_txdata && fifo_full && !pop;
    end

    always_comb begin
        rdata_d = 32'd0;
        case (reg_sel)
            2'd1:    rdata_d = {28'd0, overflow_q, busy, fifo_empty, fifo_full};
            2'd2:    rdata_d = {16'd0, bauddiv_q};
            default: rdata_d = 32'd0;
        endcase
    end

    always_comb begin
        tx_d = 1'b1;
        case (state_q)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shift_q[0];
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= bus.wdata_i[7:0];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PtrOne;
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
            case ({push, pop})
                2'b10:   count_q <= count_q + CountOne;
                2'b01:   count_q <= count_q - CountOne;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bauddiv_q  <= ResetBaudDiv;
            overflow_q <= 1'b0;
            rdata_q    <= 32'd0;
        end else begin
            if (bd_wr_lo) bauddiv_q[7:0]  <= bus.wdata_i[7:0];
            if (bd_wr_hi) bauddiv_q[15:8] <= bus.wdata_i[15:8];
            if (ovf_set) begin
                overflow_q <= 1'b1;
            end else if (ovf_clr) begin
                overflow_q <= 1'b0;
            end
            if (bus.sel_i) rdata_q <= rdata_d;
        end
    end

    // tx_q trails state_q by one edge so every bit, including start, lasts BAUDDIV+1 cycles.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            shift_q   <= 8'd0;
            bit_idx_q <= 3'd0;
            baud_q    <= 16'd0;
            tx_q      <= 1'b1;
            idle_q    <= 1'b1;
        end else begin
            tx_q   <= tx_d;
            idle_q <= (state_q == ST_IDLE) && fifo_empty;
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        shift_q <= fifo_head;
                        baud_q  <= 16'd0;
                        state_q <= ST_START;
                    end
                end
                ST_START: begin
                    if (bit_done) begin
                        baud_q    <= 16'd0;
                        bit_idx_q <= 3'd0;
                        state_q   <= ST_DATA;
                    end else begin
                        baud_q <= baud_q + 16'd1;
                    end
                end
                ST_DATA: begin
                    if (bit_done) begin
                        baud_q    <= 16'd0;
                        shift_q   <= {1'b0, shift_q[7:1]};
                        bit_idx_q <= bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) state_q <= ST_STOP;
                    end else begin
                        baud_q <= baud_q + 16'd1;
                    end
                end
                ST_STOP: begin
                    if (bit_done) begin
                        baud_q <= 16'd0;
                        if (!fifo_empty) begin
                            shift_q <= fifo_head;
                            state_q <= ST_START;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        baud_q <= baud_q + 16'd1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.rdata_o = rdata_q;
    assign tx_o        = tx_q;
    assign idle_o      = idle_q;
endmodule

// File: tb/tb_panda_uart_tx_mmio.sv
// Bench for panda_uart_tx_mmio: a line monitor decodes frames and checks them
// against a queue of bytes expected on the wire.
module tb_panda_uart_tx_mmio;
    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    logic tx_o;
    logic idle_o;

    panda_uart_tx_mmio_if bus();

    panda_uart_tx_mmio #(
        .FifoDepth    (8),
        .ResetBaudDiv (16'd867)
    ) dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .bus    (bus),
        .tx_o   (tx_o),
        .idle_o (idle_o)
    );

    always #5 clk_i = ~clk_i;

    int         pass_cnt = 0;
    int         chk_cnt  = 0;
    int         cyc      = 0;
    int         cur_div  = 867;
    int         start_cnt = 0;
    int         start_times[$];
    logic [7:0] sb_q[$];

    always @(posedge clk_i) cyc <= cyc + 1;

    initial begin
        #5000000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // Line monitor: samples each bit mid-period, abandons a frame if reset hits it.
    initial begin : monitor
        logic       prev_tx;
        logic [7:0] rx;
        logic       stop_b;
        logic       ok;
        logic [7:0] exp_b;
        int         p;
        prev_tx = 1'b1;
        forever begin
            @(negedge clk_i);
            if (!rst_i && prev_tx && !tx_o) begin
                start_cnt++;
                start_times.push_back(cyc);
                p  = cur_div + 1;
                ok = 1'b1;
                rx = 8'd0;
                stop_b = 1'b0;
                for (int j = 0; j < 9; j++) begin
                    for (int w = 0; w < ((j == 0) ? (p + p / 2) : p); w++) begin
                        @(negedge clk_i);
                        if (rst_i) ok = 1'b0;
                    end
                    if (!ok) break;
                    if (j < 8) rx[j] = tx_o;
                    else       stop_b = tx_o;
                end
                if (ok) begin
                    chk_cnt++;
                    if (sb_q.size() == 0) begin
                        $display("FAIL frame_unexpected got=%02h expected=none", rx);
                    end else begin
                        exp_b = sb_q.pop_front();
                        if (rx !== exp_b || stop_b !== 1'b1)
                            $display("FAIL frame got=%02h stop=%b expected=%02h stop=1", rx, stop_b, exp_b);
                        else begin
                            pass_cnt++;
                            $display("frame rx=%02h expected=%02h ok", rx, exp_b);
                        end
                    end
                end else begin
                    $display("frame aborted by reset");
                end
            end
            prev_tx = tx_o;
        end
    end

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] we);
        bus.sel_i   = 1'b1;
        bus.addr_i  = {28'd0, a, 2'b00};
        bus.wdata_i = d;
        bus.we_i    = we;
        @(posedge clk_i); #1;
        bus.sel_i   = 1'b0;
        bus.we_i    = 4'd0;
        $display("write addr=%0d data=%08h we=%b", a, d, we);
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        bus.sel_i  = 1'b1;
        bus.addr_i = {28'd0, a, 2'b00};
        bus.we_i   = 4'd0;
        @(posedge clk_i); #1;
        d = bus.rdata_o;
        bus.sel_i  = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
        chk_cnt++;
        if (tx_o !== 1'b1) $display("FAIL reset_tx got=%b expected=1", tx_o); else pass_cnt++;
        chk_cnt++;
        if (idle_o !== 1'b1) $display("FAIL reset_idle got=%b expected=1", idle_o); else pass_cnt++;
        chk_cnt++;
        if (bus.rdata_o !== 32'd0) $display("FAIL reset_rdata got=%08h expected=0", bus.rdata_o); else pass_cnt++;
        bus_read(2'd1, d);
        chk_cnt++;
        if (d !== 32'h2) $display("FAIL reset_status got=%08h expected=00000002", d); else pass_cnt++;
        bus_read(2'd2, d);
        chk_cnt++;
        if (d !== 32'd867) $display("FAIL reset_bauddiv got=%0d expected=867", d); else pass_cnt++;
        @(posedge clk_i); #1;
        chk_cnt++;
        if (bus.rdata_o !== 32'd867) $display("FAIL rdata_hold got=%0d expected=867", bus.rdata_o); else pass_cnt++;
        $display("test_reset done");
    endtask

    task automatic test_single_frame();
        int n;
        bus_write(2'd2, 32'd3, 4'b0011);
        cur_div = 3;
        sb_q.push_back(8'hA5);
        bus_write(2'd0, 32'hA5, 4'b0001);
        @(posedge clk_i); #1;
        chk_cnt++;
        if (tx_o !== 1'b1) $display("FAIL latency_n1 got=%b expected=1", tx_o); else pass_cnt++;
        @(posedge clk_i); #1;
        chk_cnt++;
        if (tx_o !== 1'b0) $display("FAIL latency_n2 got=%b expected=0", tx_o); else pass_cnt++;
        n = 0;
        while (!idle_o && n < 200) begin
            @(posedge clk_i); #1;
            n++;
        end
        chk_cnt++;
        if (n !== 40) $display("FAIL frame_length got=%0d expected=40", n); else pass_cnt++;
        repeat (2) @(posedge clk_i); #1;
        chk_cnt++;
        if (sb_q.size() !== 0) $display("FAIL single_drain got=%0d expected=0", sb_q.size()); else pass_cnt++;
        $display("test_single_frame done");
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        int bad;
        int s0;
        int n;
        bus_write(2'd2, 32'd1, 4'b0011);
        cur_div = 1;
        s0 = start_cnt;
        start_times.delete();
        sb_q.push_back(8'h00);
        sb_q.push_back(8'hFF);
        bus_write(2'd0, 32'h00, 4'b0001);
        bus_write(2'd0, 32'hFF, 4'b0001);
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            bus_read(2'd1, d);
            if (d[2] !== 1'b1) bad++;
        end
        chk_cnt++;
        if (bad !== 0) $display("FAIL b2b_busy got=%0d_idle_reads expected=0", bad); else pass_cnt++;
        n = 0;
        while (!idle_o && n < 100) begin
            @(posedge clk_i); #1;
            n++;
        end
        repeat (2) @(posedge clk_i); #1;
        chk_cnt++;
        if (start_cnt - s0 !== 2) $display("FAIL b2b_frames got=%0d expected=2", start_cnt - s0); else pass_cnt++;
        chk_cnt++;
        if (start_times.size() < 2)
            $display("FAIL b2b_gap got=missing expected=20");
        else if (start_times[1] - start_times[0] !== 20)
            $display("FAIL b2b_gap got=%0d expected=20", start_times[1] - start_times[0]);
        else pass_cnt++;
        chk_cnt++;
        if (sb_q.size() !== 0) $display("FAIL b2b_drain got=%0d expected=0", sb_q.size()); else pass_cnt++;
        $display("test_back_to_back done");
    endtask

    task automatic test_overflow();
        logic [31:0] d;
        int n;
        bus_write(2'd2, 32'd100, 4'b0011);
        cur_div = 100;
        for (int i = 0; i < 10; i++) begin
            if (i < 9) sb_q.push_back(8'(8'h10 + i));
            bus_write(2'd0, 32'(8'h10 + i), 4'b0001);
        end
        bus_read(2'd1, d);
        chk_cnt++;
        if (d !== 32'hD) $display("FAIL ovf_status got=%08h expected=0000000d", d); else pass_cnt++;
        bus_write(2'd1, 32'h8, 4'b0001);
        bus_read(2'd1, d);
        chk_cnt++;
        if (d !== 32'h5) $display("FAIL ovf_clear got=%08h expected=00000005", d); else pass_cnt++;
        n = 0;
        while (!idle_o && n < 12000) begin
            @(posedge clk_i); #1;
            n++;
        end
        chk_cnt++;
        if (!idle_o) $display("FAIL ovf_drain_timeout got=busy expected=idle"); else pass_cnt++;
        repeat (2) @(posedge clk_i); #1;
        chk_cnt++;
        if (sb_q.size() !== 0) $display("FAIL ovf_drain got=%0d expected=0", sb_q.size()); else pass_cnt++;
        $display("test_overflow done");
    endtask

    task automatic test_byte_lanes();
        logic [31:0] d;
        bus_write(2'd2, 32'h0063, 4'b0011);
        bus_write(2'd2, 32'h1234, 4'b0010);
        cur_div = 32'h1263;
        bus_read(2'd2, d);
        chk_cnt++;
        if (d !== 32'h1263) $display("FAIL lane_bauddiv got=%08h expected=00001263", d); else pass_cnt++;
        bus_write(2'd0, 32'h55, 4'b0010);
        repeat (3) @(posedge clk_i); #1;
        bus_read(2'd1, d);
        chk_cnt++;
        if (d !== 32'h2) $display("FAIL lane_nopush got=%08h expected=00000002", d); else pass_cnt++;
        bus_read(2'd0, d);
        chk_cnt++;
        if (d !== 32'h0) $display("FAIL txdata_read got=%08h expected=0", d); else pass_cnt++;
        bus_write(2'd3, 32'hFFFF_FFFF, 4'hF);
        bus_read(2'd3, d);
        chk_cnt++;
        if (d !== 32'h0) $display("FAIL reserved_read got=%08h expected=0", d); else pass_cnt++;
        bus_read(2'd2, d);
        chk_cnt++;
        if (d !== 32'h1263) $display("FAIL reserved_write got=%08h expected=00001263", d); else pass_cnt++;
        $display("test_byte_lanes done");
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] d;
        int s1;
        bus_write(2'd2, 32'd3, 4'b0011);
        cur_div = 3;
        bus_write(2'd0, 32'h00, 4'b0001);
        bus_write(2'd0, 32'h81, 4'b0001);
        bus_write(2'd0, 32'h42, 4'b0001);
        repeat (17) @(posedge clk_i); #1;
        chk_cnt++;
        if (tx_o !== 1'b0) $display("FAIL midframe_bit3 got=%b expected=0", tx_o); else pass_cnt++;
        rst_i = 1'b1;
        #1;
        chk_cnt++;
        if (tx_o !== 1'b1) $display("FAIL async_reset_tx got=%b expected=1", tx_o); else pass_cnt++;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        sb_q.delete();
        cur_div = 867;
        s1 = start_cnt;
        bus_read(2'd1, d);
        chk_cnt++;
        if (d !== 32'h2) $display("FAIL midreset_status got=%08h expected=00000002", d); else pass_cnt++;
        repeat (200) @(posedge clk_i); #1;
        chk_cnt++;
        if (start_cnt !== s1) $display("FAIL midreset_noframes got=%0d expected=%0d", start_cnt, s1); else pass_cnt++;
        chk_cnt++;
        if (tx_o !== 1'b1 || idle_o !== 1'b1)
            $display("FAIL midreset_line got=tx%b_idle%b expected=tx1_idle1", tx_o, idle_o);
        else pass_cnt++;
        $display("test_reset_mid_frame done");
    endtask

    initial begin
        bus.sel_i   = 1'b0;
        bus.addr_i  = 32'd0;
        bus.wdata_i = 32'd0;
        bus.we_i    = 4'd0;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_overflow();
        test_byte_lanes();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/panda_uart_tx_mmio.md
Name: panda_uart_tx_mmio

Overview:
- Memory-mapped UART transmitter on the core's data port, downstream of panda_sc_core: it consumes data_addr/data_wdata/data_we and returns read data with the same timing as panda_ram (OutputReg=0).
- Bytes written by software are queued in a FIFO and serialised as 8N1 frames, LSB first, on tx_o.
- Gives the single-cycle core console output without stalling it.

Parameters:
- FifoDepth, 8, TX FIFO entries; power of two, >=2.
- ResetBaudDiv, 16'd867, BAUDDIV reset value; bit period = BAUDDIV+1 clk cycles (867 -> 115200 baud at 100 MHz).

Ports:
- clk_i  input  1  system clock, rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- sel_i  input  1  block selected by the external address decoder this cycle.
- addr_i  input  32  byte address; only [3:2] decoded.
- wdata_i  input  32  write data.
- we_i  input  4  byte-lane write enables; all-zero = read.
- rdata_o  output  32  registered read data.
- tx_o  output  1  serial line, idles high.
- idle_o  output  1  FIFO empty and FSM in IDLE.

Behaviour:
- Register map, addr_i[3:2]:
  - 0 TXDATA, write-only: a write with we_i[0]=1 pushes wdata_i[7:0]; reads return 0.
  - 1 STATUS: bit0 full, bit1 empty, bit2 busy (FSM not IDLE), bit3 overflow (sticky; write 1 with we_i[0] to clear); other bits 0.
  - 2 BAUDDIV, RW [15:0]: we_i[0] writes [7:0], we_i[1] writes [15:8]; [31:16] read 0.
  - 3: reserved; reads 0, writes ignored.
- Access timing:
  - Write takes effect on the rising edge where sel_i=1 and the relevant we_i bit is set.
  - Read: rdata_o updates on the edge where sel_i=1, giving one-cycle latency like panda_ram.
  - rdata_o holds its value when sel_i=0.
- Reset values: rdata_o=0, tx_o=1, idle_o=1, FIFO empty, overflow=0, BAUDDIV=ResetBaudDiv, FSM=IDLE.
- FIFO:
  - Circular buffer with pointer wrap at FifoDepth and a count register.
  - Push when full: byte dropped, overflow set.
  - Push and pop on the same edge while full: push accepted, no overflow, count unchanged.
  - Pop on empty is impossible (the FSM gates it).
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx_o=1. If FIFO non-empty: pop into shift register, clear baud counter, go to START.
  - START: tx_o=0 for BAUDDIV+1 cycles, then go to DATA with bit index 0.
  - DATA: tx_o=shift[0] for BAUDDIV+1 cycles per bit; then shift right and increment index. After index 7, go to STOP.
  - STOP: tx_o=1 for BAUDDIV+1 cycles. On its last cycle: if FIFO non-empty, pop and go directly to START (no idle gap); else go to IDLE.
- Latency: with FSM in IDLE and FIFO empty, a TXDATA write on edge N makes tx_o fall on edge N+2.
- tx_o is registered (glitch-free).
- Baud counter:
  - 16-bit up-counter compared against the live BAUDDIV.
  - Comparison is >= so a mid-bit decrease ends the current bit immediately; an increase lengthens the current bit.
- BAUDDIV=0 gives 1-cycle bits; this is legal.
- Reset asserted mid-frame: tx_o=1 asynchronously, FIFO flushed, frame discarded.

Test Plan:
- Reset: assert rst_i for 2 cycles -> tx_o=1, idle_o=1, STATUS read = 0x2, BAUDDIV read = 867; rdata_o appears one edge after the read cycle.
- Single frame: BAUDDIV=3, write 0xA5 to TXDATA -> tx_o falls 2 edges later. Each bit lasts 4 cycles: 0, then 1,0,1,0,0,1,0,1, then stop 1. Frame = 40 cycles; idle_o returns to 1 after the stop bit.
- Back-to-back: BAUDDIV=1, write 0x00 then 0xFF on consecutive cycles -> second start bit begins the cycle after the first stop bit ends; no idle gap; busy stays 1 throughout.
- Overflow: BAUDDIV=100, write 10 bytes in consecutive cycles -> first byte popped, FIFO holds 8, 10th write dropped. STATUS = 0xD (full, busy, overflow). Writing 0x8 to STATUS clears bit3 only.
- Byte lanes: write 0x1234 to BAUDDIV with we_i=4'b0010 -> BAUDDIV = 0x1263 (only [15:8] changes); TXDATA write with we_i=4'b0010 -> no push.
- Reset mid-frame: during DATA bit 3 with 2 bytes queued, pulse rst_i -> tx_o=1 immediately, STATUS = 0x2, no further frames transmitted.
